// File: rtl/addsub_pkg.sv
// addsub_pkg: FSM states and signed clamp helpers for the serial adder/subtractor
package addsub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/addsub_serial_cla_digit.sv
// cla_digit: combinational D-bit carry-lookahead digit slice
module cla_digit #(
  parameter int D = 4
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic         cin,
  output logic [D-1:0] sum,
  output logic         cout,
  output logic         cmsb
);
  logic [D-1:0] p, g;
  logic [D:0]   c;
  assign p = a ^ b;
  assign g = a & b;
  assign c[0] = cin;
  for (genvar i = 0; i < D; i++) begin : g_carry
    assign c[i+1] = g[i] | (p[i] & c[i]);
  end
  assign sum  = p ^ c[D-1:0];
  assign cout = c[D];
  assign cmsb = c[D-1];
endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial W-bit add/sub with optional signed saturation
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int W = 16,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         M,
  input  logic         SAT,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] S,
  output logic         C,
  output logic         V
);
  localparam int N = W / D;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  localparam logic [63:0] SMAX = sat_max(W);
  localparam logic [63:0] SMIN = sat_min(W);
  state_t         state;
  logic [KW-1:0]  k;
  logic [W-1:0]   a_r, bb_r, res, raw;
  logic           cy, sat_r, cout, cmsb, v_n;
  logic [D-1:0]   sum;
  cla_digit #(.D(D)) u_digit (
    .a   (a_r[k*D +: D]),
    .b   (bb_r[k*D +: D]),
    .cin (cy),
    .sum (sum),
    .cout(cout),
    .cmsb(cmsb)
  );
  assign v_n = cout ^ cmsb;
  // Full result with the current digit inserted, so the last digit can feed the output mux directly
  always_comb begin
    raw = res;
    raw[k*D +: D] = sum;
  end
  // Handshake FSM, digit sequencing and registered result formation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      cy        <= 1'b0;
      res       <= '0;
      a_r       <= '0;
      bb_r      <= '0;
      sat_r     <= 1'b0;
      S         <= '0;
      C         <= 1'b0;
      V         <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r      <= A;
          bb_r     <= M ? ~B : B;
          cy       <= M;
          sat_r    <= SAT;
          k        <= '0;
          in_ready <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          res <= raw;
          cy  <= cout;
          k   <= k + 1'b1;
          if (k == KW'(N - 1)) begin
            C         <= cout;
            V         <= v_n;
            S         <= (sat_r & v_n) ? (a_r[W-1] ? SMIN[W-1:0] : SMAX[W-1:0]) : raw;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: randomized and directed checks of addsub_serial against an arithmetic model
module tb_addsub_serial;
  localparam int W = 16;
  localparam int D = 4;
  localparam int N = W / D;
  localparam longint SMAXV = (64'sd1 <<< (W - 1)) - 1;
  localparam longint SMINV = -(64'sd1 <<< (W - 1));
  localparam longint MODV  = 64'sd1 <<< W;

  logic         clk = 0;
  logic         rst_n = 0;
  logic         in_valid = 0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         M = 0;
  logic         SAT = 0;
  logic         out_valid;
  logic         out_ready = 0;
  logic [W-1:0] S;
  logic         C;
  logic         V;

  int vectors = 0;
  int miscompares = 0;

  addsub_serial #(.W(W), .D(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .M        (M),
    .SAT      (SAT),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .S        (S),
    .C        (C),
    .V        (V)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                                input logic sat, output logic [W-1:0] s, output logic c, output logic v);
    longint ua, ub, usum, sa, sb, sr;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - MODV : ua;
    sb = b[W-1] ? ub - MODV : ub;
    usum = m ? ua + (MODV - ub) : ua + ub;
    sr = m ? sa - sb : sa + sb;
    c = usum >= MODV;
    v = (sr > SMAXV) || (sr < SMINV);
    if (sat && sr > SMAXV) sr = SMAXV;
    else if (sat && sr < SMINV) sr = SMINV;
    s = (sat && v) ? W'(sr) : W'(usum % MODV);
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m, input logic sat,
                       output logic [W-1:0] s, output logic c, output logic v,
                       output int lat, output bit busy_ok);
    int guard;
    guard = 0;
    busy_ok = 1;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    A = a; B = b; M = m; SAT = sat; in_valid = 1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid = 0;
    A = W'($urandom); B = W'($urandom); M = 1'($urandom); SAT = 1'($urandom);
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ok = 0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    s = S; c = C; v = V;
  endtask

  task automatic finish_op();
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #12;
    vectors++;
    if ({in_ready, out_valid, S, C, V} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: in_ready=%b out_valid=%b S=%h C=%b V=%b, want 1 0 0 0 0", in_ready, out_valid, S, C, V);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[5] = '{16'h1234, 16'h0005, 16'h7FFF, 16'h7FFF, 16'h8000};
    logic [W-1:0] tb[5] = '{16'h0FCD, 16'h0007, 16'h0001, 16'h0001, 16'h0001};
    logic         tm[5] = '{0, 1, 0, 0, 1};
    logic         ts[5] = '{0, 0, 0, 1, 1};
    logic [W-1:0] es[5] = '{16'h2201, 16'hFFFE, 16'h8000, 16'h7FFF, 16'h8000};
    logic         ec[5] = '{0, 0, 0, 0, 1};
    logic         ev[5] = '{0, 0, 1, 1, 1};
    logic [W-1:0] s;
    logic c, v;
    int lat;
    bit busy_ok;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb[i], tm[i], ts[i], s, c, v, lat, busy_ok);
      vectors++;
      if ({s, c, v} !== {es[i], ec[i], ev[i]}) begin
        miscompares++;
        $display("FAIL directed[%0d]: S=%h C=%b V=%b, want S=%h C=%b V=%b", i, s, c, v, es[i], ec[i], ev[i]);
      end
      vectors++;
      if (lat !== N || !busy_ok) begin
        miscompares++;
        $display("FAIL directed_latency[%0d]: lat=%0d in_ready_low=%b, want lat=%0d in_ready_low=1", i, lat, busy_ok, N);
      end
      finish_op();
      vectors++;
      if ({in_ready, out_valid} !== 2'b10) begin
        miscompares++;
        $display("FAIL directed_release[%0d]: in_ready=%b out_valid=%b, want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s, es;
    logic m, sat, c, v, ec, ev;
    int lat;
    bit busy_ok;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom); b = W'($urandom); m = 1'($urandom); sat = 1'($urandom);
      if (i % 4 == 0) begin
        a = {~b[W-1], a[W-2:0]};
        b[W-1] = m ? ~a[W-1] : a[W-1];
      end
      model(a, b, m, sat, es, ec, ev);
      do_op(a, b, m, sat, s, c, v, lat, busy_ok);
      vectors++;
      if ({s, c, v} !== {es, ec, ev} || lat !== N || !busy_ok) begin
        miscompares++;
        $display("FAIL random[%0d] %h %s %h sat=%b: S=%h C=%b V=%b lat=%0d, want S=%h C=%b V=%b lat=%0d",
                 i, a, m ? "-" : "+", b, sat, s, c, v, lat, es, ec, ev, N);
      end
      finish_op();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] s, es;
    logic c, v, ec, ev;
    int lat;
    bit busy_ok;
    model(16'h7FF0, 16'h0020, 1'b0, 1'b1, es, ec, ev);
    do_op(16'h7FF0, 16'h0020, 1'b0, 1'b1, s, c, v, lat, busy_ok);
    vectors++;
    if ({s, c, v} !== {es, ec, ev}) begin
      miscompares++;
      $display("FAIL backpressure_first: S=%h C=%b V=%b, want S=%h C=%b V=%b", s, c, v, es, ec, ev);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1;
      A = W'($urandom); B = W'($urandom); M = 1'($urandom); SAT = 1'($urandom);
      @(negedge clk);
      vectors++;
      if ({out_valid, in_ready, S, C, V} !== {1'b1, 1'b0, es, ec, ev}) begin
        miscompares++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%b in_ready=%b S=%h C=%b V=%b, want 1 0 %h %b %b",
                 i, out_valid, in_ready, S, C, V, es, ec, ev);
      end
    end
    in_valid = 0;
    finish_op();
    vectors++;
    if ({in_ready, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    model(16'hA5A5, 16'h5A5B, 1'b1, 1'b0, es, ec, ev);
    do_op(16'hA5A5, 16'h5A5B, 1'b1, 1'b0, s, c, v, lat, busy_ok);
    vectors++;
    if ({s, c, v} !== {es, ec, ev} || lat !== N) begin
      miscompares++;
      $display("FAIL backpressure_next: S=%h C=%b V=%b lat=%0d, want S=%h C=%b V=%b lat=%0d", s, c, v, lat, es, ec, ev, N);
    end
    finish_op();
  endtask

  task automatic test_reset_midrun();
    logic [W-1:0] s;
    logic c, v;
    int lat;
    bit busy_ok;
    @(negedge clk);
    A = 16'hFFFF; B = 16'hFFFF; M = 0; SAT = 0; in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    vectors++;
    if ({out_valid, S, in_ready} !== {1'b0, {W{1'b0}}, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_midrun: out_valid=%b S=%h in_ready=%b, want 0 0 1", out_valid, S, in_ready);
    end
    @(negedge clk);
    rst_n = 1;
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, s, c, v, lat, busy_ok);
    vectors++;
    if ({s, c, v} !== {16'h0100, 1'b0, 1'b0} || lat !== N) begin
      miscompares++;
      $display("FAIL reset_followup: S=%h C=%b V=%b lat=%0d, want S=0100 C=0 V=0 lat=%0d", s, c, v, lat, N);
    end
    finish_op();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, multi-cycle W-bit binary adder/subtractor with optional signed saturation. It processes the operand D bits per clock through a D-bit carry-lookahead digit slice and carries between digits in a register. Operands enter and results leave through valid/ready handshakes. It sits in the datapath as the shared arithmetic unit for add/sub requests wider than a single-cycle CLA can close timing on.

## Interface
- W, 16: operand/result width; W must be a multiple of D.
- D, 4: digit width processed per cycle; N = W/D digit cycles per operation (D = W gives N = 1).
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept; high exactly in IDLE.
- A  in  W  operand A.
- B  in  W  operand B.
- M  in  1  0 = A+B, 1 = A−B (two's complement: ~B with carry-in 1).
- SAT  in  1  1 = clamp S to signed range on overflow.
- out_valid  out  1  result present; high exactly in DONE.
- out_ready  in  1  consumer takes result.
- S  out  W  sum/difference.
- C  out  1  carry out of bit W−1; raw, never affected by SAT; for subtract, 1 = no borrow.
- V  out  1  signed overflow = c[W] ^ c[W−1]; reported even when SAT clamps.

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE: in_ready=1. On in_valid & in_ready, register:
  - A;
  - Bb = M ? ~B : B;
  - carry register ← M;
  - SAT;
  - digit index k ← 0.
  - Then go to RUN.
- RUN, every cycle:
  - Digit k of A and Bb plus the carry register go into the cla_digit slice.
  - Slice definitions: p = a^b, g = a&b, c[i+1] = g[i] | p[i]&c[i].
  - At the edge, the sum digit is written to result bits [kD+D−1 : kD], the carry register ← digit carry-out, and k ← k+1.
  - On k = N−1, the slice's carry into its MSB is also captured as c[W−1], and the state goes to DONE.
- DONE, result formation:
  - V = c[W] ^ c[W−1]; C = c[W].
  - If SAT & V: S = A[W−1] ? {1,0…0} : {0,1…1}.
  - Otherwise S = raw result.
- DONE, handshake: out_valid=1; S/C/V stable. On out_ready, go to IDLE.
- Inputs are ignored outside IDLE. A, B, M and SAT may change freely after the accept edge.
- Reset (any state, including mid-RUN):
  - state ← IDLE; the in-flight operation is discarded.
  - k, carry, result, S, C, V, out_valid ← 0.
  - in_ready reads 1 once in IDLE.
  - No partial result is ever presented.

## Timing
- Accept at edge t → out_valid rises at edge t+N. Latency is N cycles regardless of operand values.
- out_valid holds until the out_ready handshake edge; it drops at that edge and in_ready rises at the same edge.
- No overlap of requests. Minimum initiation interval is N+2 cycles with out_ready tied high.
- S/C/V are registered outputs, held constant while out_valid=1 and between operations until the next DONE.
- The critical path is one D-bit ripple-lookahead slice plus result muxing, independent of W.

## Structure
- Package addsub_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - helper functions sat_max(W) and sat_min(W) returning the signed clamp values.
- Sub-module cla_digit #(D):
  - inputs: a[D], b[D], cin;
  - outputs: sum[D], cout, cmsb (carry into bit D−1);
  - purely combinational, built with a generate loop over the carry recurrence.
- Top level holds the FSM, index counter, carry/c[W−1] registers, result shift/insert logic and saturation mux.

## Test plan
- W=16, D=4:
  - A=0x1234, B=0x0FCD, M=0, SAT=0 → S=0x2201, C=0, V=0.
  - out_valid rises exactly 4 edges after accept; in_ready=0 throughout.
- Subtract with borrow: A=0x0005, B=0x0007, M=1 → S=0xFFFE, C=0, V=0.
- Positive overflow: A=0x7FFF, B=0x0001, M=0:
  - SAT=0 → S=0x8000, C=0, V=1.
  - SAT=1 → S=0x7FFF, C=0, V=1.
- Negative overflow: A=0x8000, B=0x0001, M=1, SAT=1 → S=0x8000, C=1, V=1.
- Back-pressure:
  - Hold out_ready=0 for 10 cycles in DONE → S/C/V/out_valid stable; in_valid pulses are ignored.
  - Release out_ready → in_ready=1 next cycle; next op result is correct.
- Reset and degenerate config:
  - Assert rst_n=0 asynchronously mid-RUN (k=2) → out_valid=0 and S=0 immediately; state IDLE.
  - Following op 0x00FF+0x0001 → S=0x0100.
  - Repeat suite with D=16 (N=1) and D=1 (N=16); latency equals N.
